// File: rtl/keccak_xif_pkg.sv
// rtl/keccak_xif_pkg.sv - shared types for the Keccak state-readout responder
package keccak_xif_pkg;

    localparam int KECCAK_NUM_WORDS = 50;
    localparam int KECCAK_ID_WIDTH  = 4;

    typedef enum logic {
        SNAP_EMPTY = 1'b0,
        SNAP_VALID = 1'b1
    } snap_state_e;

    typedef struct packed {
        logic [KECCAK_ID_WIDTH-1:0] id;
        logic [4:0]                 rd;
        logic [31:0]                data;
        logic                       we;
        logic                       err;
    } readout_entry_t;

endpackage

// File: rtl/keccak_xif_result_fifo.sv
// rtl/keccak_xif_result_fifo.sv - in-order result FIFO of readout entries with flush
module keccak_xif_result_fifo
    import keccak_xif_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    input  logic           push_i,
    input  readout_entry_t push_data_i,
    input  logic           pop_i,
    output readout_entry_t head_o,
    output logic           full_o,
    output logic           empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    readout_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/keccak_xif_readout.sv
// rtl/keccak_xif_readout.sv - snapshots the Keccak state and serves indexed word reads over X-IF
module keccak_xif_readout
    import keccak_xif_pkg::*;
#(
    parameter int NUM_WORDS  = KECCAK_NUM_WORDS,
    parameter int ID_WIDTH   = KECCAK_ID_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_WORDS*32-1:0] state_i,
    input  logic                   state_done_i,
    input  logic                   flush_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [ID_WIDTH-1:0]    req_id_i,
    input  logic [5:0]             req_idx_i,
    input  logic [4:0]             req_rd_i,
    output logic                   result_valid_o,
    input  logic                   result_ready_i,
    output logic [ID_WIDTH-1:0]    result_id_o,
    output logic [31:0]            result_data_o,
    output logic [4:0]             result_rd_o,
    output logic                   result_we_o,
    output logic                   result_err_o,
    output logic                   snapshot_valid_o
);

    snap_state_e             snap_state_q, snap_state_d;
    logic [NUM_WORDS*32-1:0] snap_q, snap_d;
    logic                    idx_legal;
    logic [31:0]             word;
    readout_entry_t          entry, head;
    logic                    fifo_full, fifo_empty;
    logic                    push, pop;

    always_comb begin
        snap_state_d = snap_state_q;
        snap_d       = snap_q;
        if (state_done_i) begin
            snap_state_d = SNAP_VALID;
            snap_d       = state_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snap_state_q <= SNAP_EMPTY;
            snap_q       <= '0;
        end else begin
            snap_state_q <= snap_state_d;
            snap_q       <= snap_d;
        end
    end

    // Requests read the pre-edge snapshot, so a same-cycle done never leaks in.
    assign idx_legal = (snap_state_q == SNAP_VALID) && (req_idx_i < 6'(NUM_WORDS));

    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (idx_legal && (req_idx_i == 6'(k))) begin
                word = snap_q[32*k +: 32];
            end
        end
    end

    always_comb begin
        entry      = '0;
        entry.id   = req_id_i;
        entry.rd   = req_rd_i;
        entry.data = word;
        entry.we   = idx_legal;
        entry.err  = !idx_legal;
    end

    // Ready is held low while reset is asserted so every output reads 0.
    assign req_ready_o = rst_ni && !fifo_full && !flush_i;
    assign push        = req_valid_i && req_ready_o;
    assign pop         = result_valid_o && result_ready_i;

    keccak_xif_result_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .push_i     (push),
        .push_data_i(entry),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign result_valid_o   = !fifo_empty;
    assign result_id_o      = result_valid_o ? head.id   : '0;
    assign result_data_o    = result_valid_o ? head.data : '0;
    assign result_rd_o      = result_valid_o ? head.rd   : '0;
    assign result_we_o      = result_valid_o && head.we;
    assign result_err_o     = result_valid_o && head.err;
    assign snapshot_valid_o = (snap_state_q == SNAP_VALID);

endmodule

// File: tb/tb_keccak_xif_readout.sv
// tb/tb_keccak_xif_readout.sv - scoreboard bench for the Keccak state-readout responder
module tb_keccak_xif_readout;

    localparam int NW    = 50;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic [1599:0] state_i = '0;
    logic          state_done_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [3:0]    req_id_i = '0;
    logic [5:0]    req_idx_i = '0;
    logic [4:0]    req_rd_i = '0;
    logic          result_valid_o;
    logic          result_ready_i = 1'b0;
    logic [3:0]    result_id_o;
    logic [31:0]   result_data_o;
    logic [4:0]    result_rd_o;
    logic          result_we_o;
    logic          result_err_o;
    logic          snapshot_valid_o;

    keccak_xif_readout dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .state_i         (state_i),
        .state_done_i    (state_done_i),
        .flush_i         (flush_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_id_i        (req_id_i),
        .req_idx_i       (req_idx_i),
        .req_rd_i        (req_rd_i),
        .result_valid_o  (result_valid_o),
        .result_ready_i  (result_ready_i),
        .result_id_o     (result_id_o),
        .result_data_o   (result_data_o),
        .result_rd_o     (result_rd_o),
        .result_we_o     (result_we_o),
        .result_err_o    (result_err_o),
        .snapshot_valid_o(snapshot_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_snap[NW];
    logic [31:0] load_words[NW];
    bit          ref_valid = 1'b0;
    bit          acc;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares presented results against the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_ni) begin
                check("result_valid", result_valid_o, exp_q.size() != 0);
                check("snapshot_valid", snapshot_valid_o, ref_valid);
                if (result_valid_o && exp_q.size() != 0) begin
                    check("result_id", result_id_o, exp_q[0].id);
                    check("result_rd", result_rd_o, exp_q[0].rd);
                    check("result_data", result_data_o, exp_q[0].data);
                    check("result_we", result_we_o, exp_q[0].we);
                    check("result_err", result_err_o, exp_q[0].err);
                    if (result_ready_i && !flush_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cycle(input bit v, input int idx, input int id, input int rd,
                         input bit done, input bit fl, input bit rr);
        int   pre;
        bit   legal;
        exp_t e;
        @(negedge clk);
        req_valid_i    = v;
        req_idx_i      = 6'(idx);
        req_id_i       = 4'(id);
        req_rd_i       = 5'(rd);
        state_done_i   = done;
        flush_i        = fl;
        result_ready_i = rr;
        for (int k = 0; k < NW; k++) state_i[32*k +: 32] = load_words[k];
        pre = exp_q.size();
        #2;
        check("req_ready", req_ready_o, rst_ni && (pre < DEPTH) && !fl);
        acc = v && rst_ni && (pre < DEPTH) && !fl;
        if (fl) exp_q.delete();
        if (acc) begin
            legal  = ref_valid && (idx < NW);
            e.id   = 4'(id);
            e.rd   = 5'(rd);
            e.data = legal ? ref_snap[idx] : 32'h0;
            e.we   = legal;
            e.err  = !legal;
            exp_q.push_back(e);
        end
        if (done && rst_ni) begin
            ref_snap  = load_words;
            ref_valid = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        state_done_i = 1'b0;
        flush_i      = 1'b0;
        exp_q.delete();
        ref_valid = 1'b0;
        #1;
        check("rst_result_valid", result_valid_o, 0);
        check("rst_result_id", result_id_o, 0);
        check("rst_result_data", result_data_o, 0);
        check("rst_result_rd", result_rd_o, 0);
        check("rst_result_we", result_we_o, 0);
        check("rst_result_err", result_err_o, 0);
        check("rst_snapshot_valid", snapshot_valid_o, 0);
        check("rst_req_ready", req_ready_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < NW; k++) load_words[k] = 32'hA500_0000 | 32'(k);
        do_reset();

        // No snapshot yet: error response
        cycle(1, 0, 1, 2, 0, 0, 1);
        idle(1);
        // Capture pattern, read word 7
        cycle(0, 0, 0, 0, 1, 0, 1);
        cycle(1, 7, 3, 10, 0, 0, 1);
        idle(1);
        // Out-of-range and last word
        cycle(1, 50, 4, 11, 0, 0, 1);
        cycle(1, 49, 5, 12, 0, 0, 1);
        idle(2);

        // Backpressure: third request blocked until a pop frees space
        cycle(1, 1, 6, 1, 0, 0, 0);
        cycle(1, 2, 7, 2, 0, 0, 0);
        cycle(1, 3, 8, 3, 0, 0, 0);
        check("third_blocked", acc, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int t = 0; t < 5; t++) begin
            cycle(1, 3, 8, 3, 0, 0, 1);
            if (acc) break;
        end
        check("third_accepted", acc, 1);
        idle(3);

        // Same-cycle done does not affect the accepted request
        load_words[5] = 32'h1234_5678;
        cycle(1, 5, 9, 5, 1, 0, 1);
        cycle(1, 5, 10, 5, 0, 0, 1);
        idle(2);

        // Flush with two queued entries
        cycle(1, 0, 11, 1, 0, 0, 0);
        cycle(1, 1, 12, 2, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 1);
        idle(2);

        // Reset with full FIFO and valid snapshot
        cycle(1, 2, 13, 3, 0, 0, 0);
        cycle(1, 3, 14, 4, 0, 0, 0);
        do_reset();
        cycle(1, 0, 15, 6, 0, 0, 1);
        idle(2);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            bit done;
            done = ($urandom_range(0, 15) == 0);
            if (done) for (int k = 0; k < NW; k++) load_words[k] = $urandom;
            cycle($urandom_range(0, 1) == 1,
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(50, 63)) : int'($urandom_range(0, 49)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
                  done, $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keccak_xif_readout.md
Name: keccak_xif_readout

Overview:
- Responder for the Keccak coprocessor's state-readout instruction over the CV-X-IF result interface.
- Snapshots the 1600-bit permutation output when the permutation reports done.
- Accepts indexed 32-bit word read requests from the issue stage.
- Returns the data through a small in-order result FIFO with a valid/ready handshake, so a stalled core never loses or duplicates a result.

Parameters:
- NUM_WORDS, 50, number of 32-bit words in the state (1600/32).
- ID_WIDTH, 4, width of the X-IF instruction id.
- FIFO_DEPTH, 2, result FIFO entries (power of two, >=2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- state_i  in  1600  permutation output; word k = state_i[32k+31:32k]
- state_done_i  in  1  one-cycle pulse: permutation finished, state_i valid this cycle
- flush_i  in  1  kill all pending results (pipeline flush)
- req_valid_i  in  1  readout instruction issued
- req_ready_o  out  1  request accepted when req_valid_i && req_ready_o
- req_id_i  in  ID_WIDTH  instruction id
- req_idx_i  in  6  word index (from rs1[5:0])
- req_rd_i  in  5  destination register
- result_valid_o  out  1  result available
- result_ready_i  in  1  core takes result
- result_id_o  out  ID_WIDTH  id of returned instruction
- result_data_o  out  32  word data
- result_rd_o  out  5  destination register
- result_we_o  out  1  write-back enable
- result_err_o  out  1  request was illegal
- snapshot_valid_o  out  1  a snapshot has been captured since reset

Behaviour:
Reset:
- All outputs 0; snapshot register and FIFO cleared; snap state SNAP_EMPTY.
- Reset asserted mid-operation discards all state immediately.

Snapshot FSM (SNAP_EMPTY, SNAP_VALID):
- Any state: state_done_i captures state_i at the clock edge and moves to SNAP_VALID.
- SNAP_VALID persists; a later state_done_i overwrites the snapshot.
- snapshot_valid_o is high in SNAP_VALID.

Request acceptance:
- req_ready_o = !full && !flush_i.
- On accept, the entry {id, rd, data, we, err} is computed from the pre-edge snapshot and pushed.
- A state_done_i in the same cycle as an accept does not affect that request; the request returns the old data.
- Legal request (SNAP_VALID and req_idx_i < NUM_WORDS): data = snapshot word idx, we=1, err=0.
- Illegal request (idx >= NUM_WORDS, or SNAP_EMPTY): data=0, we=0, err=1, id still returned.

Result FIFO:
- Registered and in-order. Latency: accept at edge N gives result_valid_o high from cycle N+1.
- result_valid_o = !empty; outputs come from the head entry.
- Pop on result_valid_o && result_ready_i.
- While valid && !ready, all result_* outputs are held stable.
- Push and pop in the same cycle are allowed when not full; count is unchanged and pointers wrap modulo FIFO_DEPTH.
- When full there is no accept, even if a pop occurs that cycle (no bypass); req_ready_o reflects the pre-edge full flag.
- Full and empty are derived from an occupancy counter of width clog2(FIFO_DEPTH)+1.

Flush:
- flush_i empties the FIFO at the next edge (pointers and count reset) and blocks acceptance that cycle.
- A pop in the same cycle as the flush is ignored.
- The snapshot is preserved.

Decomposition:
- keccak_xif_pkg gets:
  - KECCAK_NUM_WORDS = 50
  - readout_entry_t packed struct {id, rd, data, we, err}
  - snap_state_e enum
- Sub-module keccak_xif_result_fifo: a generic FIFO of readout_entry_t with push/pop/flush, full/empty.
- The top holds the snapshot FSM, index decode, and request/response glue.

Test Plan:
1. Load a state with word k = 32'hA5000000|k, pulse state_done_i, request idx=7, id=3, rd=10 with result_ready_i=1 -> next cycle result_valid_o=1, data=32'hA5000007, id=3, rd=10, we=1, err=0.
2. After reset with no snapshot, request idx=0 -> err=1, we=0, data=0. Then request idx=50 after a snapshot -> err=1. Request idx=49 -> data=32'hA5000031.
3. result_ready_i=0, issue 3 back-to-back requests (idx 1,2,3) -> first two accepted, req_ready_o=0 on the third. Outputs hold idx 1 data stable. Releasing ready returns 1,2 in order, then the third is accepted.
4. Accept request idx=5 in the same cycle state_done_i loads a new state with word5=32'h12345678 -> returned data is the old word5. The next request returns 32'h12345678.
5. With 2 entries queued, assert flush_i with result_ready_i=1 -> result_valid_o=0 the next cycle, no result delivered, snapshot_valid_o stays 1.
6. Assert rst_ni=0 with a full FIFO and valid snapshot -> all outputs 0 asynchronously. After release, a request idx=0 returns err=1.
